iic_seq_ctrl: RTL and testbench

- Transaction sequencer for the SHT21 IIC master.
- Takes a measurement request and command byte, then steps the phase sub-blocks in order: start, byte write, ack check, read byte, read-ack/nack, stop.
- Each phase is cleared, activated and awaited through its done pulse.
- Contains the SCL timing generator that produces the scl_ls/scl_lc/scl_hs/scl_hc strobes consumed by all phase blocks.

---
 rtl/iic_pkg.sv | 42 ++++
 rtl/iic_scl_gen.sv | 69 ++++++
 rtl/iic_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_iic_seq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the SHT21 IIC master: phase codes, error codes and
// SHT21 command bytes.
package iic_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START     = 4'd1,
    ST_WR_ADDR   = 4'd2,
    ST_ACK_CHK   = 4'd3,
    ST_WR_CMD    = 4'd4,
    ST_RESTART   = 4'd5,
    ST_RD_ADDR   = 4'd6,
    ST_RD_MSB    = 4'd7,
    ST_RDACK     = 4'd8,
    ST_RD_LSB    = 4'd9,
    ST_RD_CRC    = 4'd10,
    ST_NACK      = 4'd11,
    ST_DONE      = 4'd12,
    ST_STOP      = 4'd13,
    ST_POLL_WAIT = 4'd14,
    ST_ERR       = 4'd15
  } phase_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_ADDR_NACK = 2'd1;
  localparam logic [1:0] ERR_CMD_NACK  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

  localparam logic [7:0] CMD_T_HOLD    = 8'hE3;
  localparam logic [7:0] CMD_RH_HOLD   = 8'hE5;
  localparam logic [7:0] CMD_T_NOHOLD  = 8'hF3;
  localparam logic [7:0] CMD_RH_NOHOLD = 8'hF5;

  // States that drive a phase block through the clear/activate/done handshake.
  function automatic logic is_phase(input phase_e p);
    case (p)
      ST_IDLE, ST_DONE, ST_POLL_WAIT, ST_ERR: return 1'b0;
      default:                                return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/iic_scl_gen.sv
// SCL timing generator: one SCL period every DIV clocks while run is high,
// with registered quarter-period strobes.
module iic_scl_gen
  import iic_pkg::*;
#(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic scl,
  output logic scl_ls,
  output logic scl_lc,
  output logic scl_hs,
  output logic scl_hc
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] cnt_r;
  logic         scl_r;
  logic         ls_r;
  logic         lc_r;
  logic         hs_r;
  logic         hc_r;

  // Period counter, parked at zero while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (!run) begin
      cnt_r <= '0;
    end else if (cnt_r == W'(DIV - 1)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + W'(1);
    end
  end

  // Strobe and SCL level decode from the counter.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      scl_r <= 1'b1;
      ls_r  <= 1'b0;
      lc_r  <= 1'b0;
      hs_r  <= 1'b0;
      hc_r  <= 1'b0;
    end else begin
      ls_r <= (cnt_r == W'(0));
      lc_r <= (cnt_r == W'(DIV / 4));
      hs_r <= (cnt_r == W'(DIV / 2));
      hc_r <= (cnt_r == W'((3 * DIV) / 4));
      if (cnt_r == W'(0)) begin
        scl_r <= 1'b0;
      end else if (cnt_r == W'(DIV / 2)) begin
        scl_r <= 1'b1;
      end else begin
        scl_r <= scl_r;
      end
    end
  end

  assign scl    = scl_r;
  assign scl_ls = ls_r;
  assign scl_lc = lc_r;
  assign scl_hs = hs_r;
  assign scl_hc = hc_r;

endmodule

// File: rtl/iic_seq_ctrl.sv
// SHT21 transaction sequencer: walks the IIC phase blocks through a
// measurement read, with NACK polling, per-phase timeout and SCL generation.
module iic_seq_ctrl
  import iic_pkg::*;
#(
  parameter int       CLK_HZ   = 100_000_000,
  parameter int       SCL_HZ   = 100_000,
  parameter bit [6:0] DEV_ADDR = 7'h40,
  parameter int       MAX_POLL = 8,
  parameter int       POLL_GAP = 100_000,
  parameter int       TIMEOUT  = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [7:0]  cmd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] result,
  output logic [7:0]  crc,
  output logic        scl,
  output logic        scl_ls,
  output logic        scl_lc,
  output logic        scl_hs,
  output logic        scl_hc,
  output logic [3:0]  state_code,
  output logic        ph_clr,
  output logic        ph_act,
  output logic [7:0]  wr_byte,
  input  logic        ack_ok,
  input  logic [7:0]  rd_byte,
  input  logic        ph_done
);

  localparam int DIV = CLK_HZ / SCL_HZ;
  localparam int CW  = $clog2(((TIMEOUT > POLL_GAP) ? TIMEOUT : POLL_GAP) + 1);
  localparam int PW  = $clog2(MAX_POLL + 1);

  phase_e          state_r, state_nxt_s, prev_r, stop_nxt_r, stop_nxt_s;
  logic [1:0]      err_code_r, err_code_nxt_s;
  logic [PW-1:0]   poll_r, poll_nxt_s;
  logic [CW-1:0]   tmo_r;
  logic [7:0]      cmd_r, msb_r, lsb_r, crc_sh_r, wr_byte_r, wr_byte_nxt_s;
  logic [15:0]     result_r;
  logic [7:0]      crc_r;
  logic            busy_r, done_r, err_r, ph_clr_r, ph_act_r;
  logic            ph_ev_s, tmo_s, chg_s;
  logic            busy_nxt_s, done_nxt_s, err_nxt_s, ph_clr_nxt_s, ph_act_nxt_s;

  assign ph_ev_s = ph_act_r & ph_done;
  assign tmo_s   = ph_act_r & ~ph_done & (tmo_r == CW'(TIMEOUT - 1));

  // State register with transaction context (previous phase, post-STOP target, poll count, cycle counter).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      prev_r     <= ST_IDLE;
      stop_nxt_r <= ST_DONE;
      err_code_r <= ERR_NONE;
      poll_r     <= '0;
      tmo_r      <= '0;
    end else begin
      state_r    <= state_nxt_s;
      stop_nxt_r <= stop_nxt_s;
      err_code_r <= err_code_nxt_s;
      poll_r     <= poll_nxt_s;
      if (chg_s) begin
        prev_r <= state_r;
        tmo_r  <= '0;
      end else if (tmo_r != {CW{1'b1}}) begin
        tmo_r  <= tmo_r + CW'(1);
      end
    end
  end

  // Next-state decision; ACK_CHK and RDACK branch on the phase that preceded them.
  always_comb begin
    state_nxt_s    = state_r;
    stop_nxt_s     = stop_nxt_r;
    err_code_nxt_s = err_code_r;
    poll_nxt_s     = poll_r;
    if (tmo_s) begin
      err_code_nxt_s = ERR_TIMEOUT;
      if (state_r == ST_STOP) begin
        state_nxt_s = ST_ERR;
      end else begin
        state_nxt_s = ST_STOP;
        stop_nxt_s  = ST_ERR;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            state_nxt_s    = ST_START;
            stop_nxt_s     = ST_DONE;
            err_code_nxt_s = ERR_NONE;
            poll_nxt_s     = '0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_POLL_WAIT: begin
          if (tmo_r == CW'(POLL_GAP - 1)) begin
            state_nxt_s = ST_RESTART;
          end else begin
            state_nxt_s = ST_POLL_WAIT;
          end
        end
        ST_DONE, ST_ERR: state_nxt_s = ST_IDLE;
        default: begin
          if (ph_ev_s) begin
            case (state_r)
              ST_START:                           state_nxt_s = ST_WR_ADDR;
              ST_WR_ADDR, ST_WR_CMD, ST_RD_ADDR:  state_nxt_s = ST_ACK_CHK;
              ST_RESTART:                         state_nxt_s = ST_RD_ADDR;
              ST_RD_MSB, ST_RD_LSB:               state_nxt_s = ST_RDACK;
              ST_RD_CRC:                          state_nxt_s = ST_NACK;
              ST_NACK: begin
                state_nxt_s = ST_STOP;
                stop_nxt_s  = ST_DONE;
              end
              ST_STOP:                            state_nxt_s = stop_nxt_r;
              ST_RDACK: begin
                if (prev_r == ST_RD_MSB) begin
                  state_nxt_s = ST_RD_LSB;
                end else begin
                  state_nxt_s = ST_RD_CRC;
                end
              end
              ST_ACK_CHK: begin
                if (ack_ok) begin
                  case (prev_r)
                    ST_WR_ADDR: state_nxt_s = ST_WR_CMD;
                    ST_WR_CMD:  state_nxt_s = ST_RESTART;
                    default:    state_nxt_s = ST_RD_MSB;
                  endcase
                end else begin
                  state_nxt_s = ST_STOP;
                  stop_nxt_s  = ST_ERR;
                  case (prev_r)
                    ST_WR_ADDR: err_code_nxt_s = ERR_ADDR_NACK;
                    ST_WR_CMD:  err_code_nxt_s = ERR_CMD_NACK;
                    default: begin
                      // cmd[4] marks a no-hold command: a NACKed read address means "not ready yet".
                      if (!cmd_r[4]) begin
                        err_code_nxt_s = ERR_ADDR_NACK;
                      end else if (poll_r == PW'(MAX_POLL)) begin
                        err_code_nxt_s = ERR_TIMEOUT;
                      end else begin
                        poll_nxt_s = poll_r + PW'(1);
                        stop_nxt_s = ST_POLL_WAIT;
                      end
                    end
                  endcase
                end
              end
              default: state_nxt_s = ST_IDLE;
            endcase
          end else begin
            state_nxt_s = state_r;
          end
        end
      endcase
    end
  end

  // Next values of the registered outputs, derived from the pending transition.
  always_comb begin
    chg_s         = (state_nxt_s != state_r);
    ph_clr_nxt_s  = chg_s & is_phase(state_nxt_s);
    ph_act_nxt_s  = ~chg_s & (ph_clr_r | ph_act_r);
    done_nxt_s    = chg_s & (state_nxt_s == ST_DONE);
    err_nxt_s     = chg_s & (state_nxt_s == ST_ERR);
    wr_byte_nxt_s = wr_byte_r;
    case (state_nxt_s)
      ST_IDLE, ST_DONE, ST_ERR: busy_nxt_s = 1'b0;
      default:                  busy_nxt_s = 1'b1;
    endcase
    if (chg_s) begin
      case (state_nxt_s)
        ST_WR_ADDR: wr_byte_nxt_s = {DEV_ADDR, 1'b0};
        ST_WR_CMD:  wr_byte_nxt_s = cmd_r;
        ST_RD_ADDR: wr_byte_nxt_s = {DEV_ADDR, 1'b1};
        default:    wr_byte_nxt_s = wr_byte_r;
      endcase
    end else begin
      wr_byte_nxt_s = wr_byte_r;
    end
  end

  // Output registers plus received-byte capture; result/crc publish only on success.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      ph_clr_r  <= 1'b0;
      ph_act_r  <= 1'b0;
      wr_byte_r <= 8'h00;
      cmd_r     <= 8'h00;
      msb_r     <= 8'h00;
      lsb_r     <= 8'h00;
      crc_sh_r  <= 8'h00;
      result_r  <= 16'h0000;
      crc_r     <= 8'h00;
    end else begin
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      err_r     <= err_nxt_s;
      ph_clr_r  <= ph_clr_nxt_s;
      ph_act_r  <= ph_act_nxt_s;
      wr_byte_r <= wr_byte_nxt_s;
      if (state_r == ST_IDLE && req) begin
        cmd_r <= cmd;
      end
      if (ph_ev_s) begin
        case (state_r)
          ST_RD_MSB: msb_r    <= rd_byte;
          ST_RD_LSB: lsb_r    <= rd_byte;
          ST_RD_CRC: crc_sh_r <= rd_byte;
          default:   msb_r    <= msb_r;
        endcase
      end
      if (done_nxt_s) begin
        result_r <= {msb_r, lsb_r};
        crc_r    <= crc_sh_r;
      end
    end
  end

  iic_scl_gen #(.DIV(DIV)) u_scl_gen (
    .clk    (clk),
    .rst    (rst),
    .run    (busy_r),
    .scl    (scl),
    .scl_ls (scl_ls),
    .scl_lc (scl_lc),
    .scl_hs (scl_hs),
    .scl_hc (scl_hc)
  );

  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign err_code   = err_code_r;
  assign result     = result_r;
  assign crc        = crc_r;
  assign state_code = state_r;
  assign ph_clr     = ph_clr_r;
  assign ph_act     = ph_act_r;
  assign wr_byte    = wr_byte_r;

endmodule

// File: tb/tb_iic_seq_ctrl.sv
// Directed bench for iic_seq_ctrl: the bench plays every phase block and
// checks sequencing, results, errors, polling, timeout and SCL strobes.
module tb_iic_seq_ctrl;
  import iic_pkg::*;

  localparam int POLL_GAP = 20;
  localparam int TIMEOUT  = 3000;
  localparam int MAX_POLL = 8;

  logic        clk = 1'b0;
  logic        rst, req, ack_ok, ph_done;
  logic [7:0]  cmd, rd_byte, wr_byte, crc;
  logic        busy, done, err, scl, scl_ls, scl_lc, scl_hs, scl_hc, ph_clr, ph_act;
  logic [1:0]  err_code;
  logic [15:0] result;
  logic [3:0]  state_code;

  int n_chk = 0, n_fail = 0, cyc = 0, done_cnt = 0;
  logic [7:0] cur_cmd = 8'h00;

  iic_seq_ctrl #(
    .CLK_HZ(100_000_000), .SCL_HZ(100_000), .DEV_ADDR(7'h40),
    .MAX_POLL(MAX_POLL), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .result(result), .crc(crc), .scl(scl), .scl_ls(scl_ls),
    .scl_lc(scl_lc), .scl_hs(scl_hs), .scl_hc(scl_hc), .state_code(state_code),
    .ph_clr(ph_clr), .ph_act(ph_act), .wr_byte(wr_byte), .ack_ok(ack_ok),
    .rd_byte(rd_byte), .ph_done(ph_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clr(input logic [3:0] code);
    int n = 0;
    while (ph_clr !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    check($sformatf("clr_%0d", code), 32'(ph_clr), 32'h1);
    check($sformatf("state_%0d", code), 32'(state_code), 32'(code));
    check($sformatf("act_lo_%0d", code), 32'(ph_act), 32'h0);
    if (code == 4'd2) check("wr_addr", 32'(wr_byte), 32'h80);
    else if (code == 4'd4) check("wr_cmd", 32'(wr_byte), 32'(cur_cmd));
    else if (code == 4'd6) check("rd_addr", 32'(wr_byte), 32'h81);
  endtask

  task automatic finish_phase(input logic ack, input logic [7:0] rb);
    step();
    step();
    ph_done = 1'b1; ack_ok = ack; rd_byte = rb;
    step();
    ph_done = 1'b0; ack_ok = 1'b0; rd_byte = 8'h00;
  endtask

  task automatic do_phase(input logic [3:0] code, input logic ack, input logic [7:0] rb);
    wait_clr(code);
    finish_phase(ack, rb);
  endtask

  task automatic issue_req(input logic [7:0] c);
    cur_cmd = c; cmd = c; req = 1'b1;
    step();
    req = 1'b0;
    check("busy_rise", 32'(busy), 32'h1);
  endtask

  task automatic front();
    do_phase(4'd1, 1'b1, 8'h00);
    do_phase(4'd2, 1'b1, 8'h00);
    do_phase(4'd3, 1'b1, 8'h00);
    do_phase(4'd4, 1'b1, 8'h00);
    do_phase(4'd3, 1'b1, 8'h00);
  endtask

  task automatic rd_try(input logic ack);
    do_phase(4'd5, 1'b1, 8'h00);
    do_phase(4'd6, 1'b1, 8'h00);
    do_phase(4'd3, ack, 8'h00);
  endtask

  task automatic rd_tail(input logic [7:0] m, input logic [7:0] l, input logic [7:0] c);
    do_phase(4'd7, 1'b1, m);
    do_phase(4'd8, 1'b1, 8'h00);
    do_phase(4'd9, 1'b1, l);
    do_phase(4'd8, 1'b1, 8'h00);
    do_phase(4'd10, 1'b1, c);
    do_phase(4'd11, 1'b1, 8'h00);
    do_phase(4'd13, 1'b1, 8'h00);
  endtask

  task automatic poll_wait();
    int n = 0;
    check("poll_state", 32'(state_code), 32'd14);
    check("poll_noclr", 32'(ph_clr), 32'h0);
    while (state_code == 4'd14 && n < 1000) begin
      step();
      n++;
    end
    check("poll_gap", 32'(n), 32'(POLL_GAP));
  endtask

  task automatic check_done(input logic [15:0] r, input logic [7:0] c);
    check("done_state", 32'(state_code), 32'd12);
    check("done_pulse", 32'(done), 32'h1);
    check("done_busy", 32'(busy), 32'h0);
    check("done_err", 32'(err), 32'h0);
    check("result", 32'(result), 32'(r));
    check("crc", 32'(crc), 32'(c));
    step();
    check("done_one", 32'(done), 32'h0);
    check("back_idle", 32'(state_code), 32'd0);
  endtask

  task automatic check_err(input logic [1:0] code, input logic [15:0] r);
    check("err_state", 32'(state_code), 32'd15);
    check("err_pulse", 32'(err), 32'h1);
    check("err_code", 32'(err_code), 32'(code));
    check("err_busy", 32'(busy), 32'h0);
    check("err_result_kept", 32'(result), 32'(r));
    step();
    check("err_one", 32'(err), 32'h0);
    check("err_code_hold", 32'(err_code), 32'(code));
    check("err_idle", 32'(state_code), 32'd0);
  endtask

  initial begin
    int t_ls, t_ls2, t_lc, t_hs, t_hc, c0, d0;
    rst = 1'b1; req = 1'b0; cmd = 8'h00; ack_ok = 1'b0; rd_byte = 8'h00; ph_done = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_scl", 32'(scl), 32'h1);
    check("rst_strobes", 32'({scl_ls, scl_lc, scl_hs, scl_hc}), 32'h0);
    check("rst_state", 32'(state_code), 32'h0);
    check("rst_clr_act", 32'({ph_clr, ph_act}), 32'h0);
    check("rst_outs", 32'({done, err, err_code, wr_byte}), 32'h0);
    check("rst_result", 32'({result, crc}), 32'h0);

    // Hold-mode read; an early ph_done during the clear cycle must be ignored.
    issue_req(CMD_T_HOLD);
    wait_clr(4'd1);
    ph_done = 1'b1;
    step();
    ph_done = 1'b0;
    check("ignore_done_state", 32'(state_code), 32'd1);
    check("ignore_done_act", 32'(ph_act), 32'h1);
    finish_phase(1'b1, 8'h00);
    do_phase(4'd2, 1'b1, 8'h00);
    do_phase(4'd3, 1'b1, 8'h00);
    do_phase(4'd4, 1'b1, 8'h00);
    do_phase(4'd3, 1'b1, 8'h00);
    rd_try(1'b1);
    rd_tail(8'h66, 8'h5C, 8'hA1);
    check_done(16'h665C, 8'hA1);

    // Address NACK.
    issue_req(CMD_RH_HOLD);
    do_phase(4'd1, 1'b1, 8'h00);
    do_phase(4'd2, 1'b1, 8'h00);
    do_phase(4'd3, 1'b0, 8'h00);
    do_phase(4'd13, 1'b1, 8'h00);
    check_err(2'd1, 16'h665C);
    check("crc_kept", 32'(crc), 32'hA1);

    // No-hold poll: two NACKs then ACK.
    issue_req(CMD_T_NOHOLD);
    front();
    for (int i = 0; i < 2; i++) begin
      rd_try(1'b0);
      do_phase(4'd13, 1'b1, 8'h00);
      poll_wait();
    end
    rd_try(1'b1);
    rd_tail(8'h12, 8'h34, 8'h56);
    check_done(16'h1234, 8'h56);

    // Poll exhaustion: first attempt plus MAX_POLL retries, all NACKed.
    issue_req(CMD_RH_NOHOLD);
    front();
    rd_try(1'b0);
    do_phase(4'd13, 1'b1, 8'h00);
    for (int i = 0; i < MAX_POLL; i++) begin
      poll_wait();
      rd_try(1'b0);
      do_phase(4'd13, 1'b1, 8'h00);
    end
    check_err(2'd3, 16'h1234);

    // Timeout in WR_CMD, measuring SCL strobe spacing while the phase hangs.
    issue_req(CMD_T_HOLD);
    do_phase(4'd1, 1'b1, 8'h00);
    do_phase(4'd2, 1'b1, 8'h00);
    do_phase(4'd3, 1'b1, 8'h00);
    wait_clr(4'd4);
    c0 = cyc; t_ls = -1; t_ls2 = -1; t_lc = -1; t_hs = -1; t_hc = -1;
    while (cyc < c0 + TIMEOUT - 1) begin
      step();
      if (scl_ls) begin
        if (t_ls < 0) begin
          t_ls = cyc;
          check("scl_low_at_ls", 32'(scl), 32'h0);
        end else if (t_ls2 < 0) begin
          t_ls2 = cyc;
        end
      end
      if (t_ls >= 0 && scl_lc && t_lc < 0) t_lc = cyc;
      if (t_ls >= 0 && scl_hs && t_hs < 0) begin
        t_hs = cyc;
        check("scl_high_at_hs", 32'(scl), 32'h1);
      end
      if (t_ls >= 0 && scl_hc && t_hc < 0) t_hc = cyc;
    end
    check("lc_offset", 32'(t_lc - t_ls), 32'd250);
    check("hs_offset", 32'(t_hs - t_ls), 32'd500);
    check("hc_offset", 32'(t_hc - t_ls), 32'd750);
    check("period", 32'(t_ls2 - t_ls), 32'd1000);
    check("tmo_act_still", 32'(ph_act), 32'h1);
    step();
    check("tmo_act_drop", 32'(ph_act), 32'h0);
    check("tmo_state", 32'(state_code), 32'd13);
    check("tmo_code", 32'(err_code), 32'd3);
    check("tmo_stop_clr", 32'(ph_clr), 32'h1);
    finish_phase(1'b1, 8'h00);
    check_err(2'd3, 16'h1234);

    // A req while busy is dropped; exactly one done follows.
    d0 = done_cnt;
    issue_req(CMD_RH_HOLD);
    wait_clr(4'd1);
    cmd = CMD_T_NOHOLD; req = 1'b1;
    step();
    req = 1'b0;
    finish_phase(1'b1, 8'h00);
    do_phase(4'd2, 1'b1, 8'h00);
    do_phase(4'd3, 1'b1, 8'h00);
    do_phase(4'd4, 1'b1, 8'h00);
    do_phase(4'd3, 1'b1, 8'h00);
    rd_try(1'b1);
    rd_tail(8'hBE, 8'hEF, 8'h42);
    check_done(16'hBEEF, 8'h42);
    repeat (20) step();
    check("one_done", 32'(done_cnt - d0), 32'd1);
    check("stay_idle", 32'(state_code), 32'd0);

    // Reset in RD_LSB returns straight to IDLE.
    issue_req(CMD_T_HOLD);
    front();
    rd_try(1'b1);
    do_phase(4'd7, 1'b1, 8'h11);
    do_phase(4'd8, 1'b1, 8'h00);
    wait_clr(4'd9);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_scl", 32'(scl), 32'h1);
    check("mid_rst_state", 32'(state_code), 32'd0);
    check("mid_rst_act", 32'(ph_act), 32'h0);
    check("mid_rst_result", 32'(result), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
